// File: rtl/abus_avalon_bridge.sv
// rtl/abus_avalon_bridge.sv - Saturn A-bus cartridge cycles to 32-bit Avalon-MM on-chip RAM bridge
// Optional one-word read cache: define ABUS_READ_CACHE_EN.
module abus_avalon_bridge #(
    parameter int READ_LATENCY = 1,
    parameter int HALF_SWAP    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        abus_cs,
    input  logic        abus_rd,
    input  logic [1:0]  abus_wr,
    input  logic [12:0] abus_addr,
    input  logic [15:0] abus_wdata,
    output logic [15:0] abus_rdata,
    output logic        abus_wait,
    output logic [11:0] avm_address,
    output logic [3:0]  avm_byteenable,
    output logic        avm_chipselect,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RD_ISSUE = 2'd1;
    localparam logic [1:0] S_WR_ISSUE = 2'd2;
    localparam logic [1:0] S_HOLD     = 2'd3;

    localparam logic [1:0] LAT_LAST = READ_LATENCY[1:0];
    localparam logic       SWAP     = HALF_SWAP[0];

    logic [1:0] state;
    logic       rd_q;
    logic [1:0] wr_q;
    logic [1:0] lat_cnt;
    logic       rd_upper;

    logic       rd_edge;
    logic       wr_edge;
    logic       upper_sel;
    logic [3:0] wr_be;
    logic       strobes_idle;
    logic       capture;

    assign rd_edge      = abus_cs & abus_rd & ~rd_q;
    assign wr_edge      = abus_cs & (|(abus_wr & ~wr_q));
    // Half 0 is the big-endian upper half unless swapped.
    assign upper_sel    = ~(abus_addr[0] ^ SWAP);
    assign wr_be        = upper_sel ? {abus_wr, 2'b00} : {2'b00, abus_wr};
    assign strobes_idle = ~abus_cs | (~abus_rd & (abus_wr == 2'b00));
    assign capture      = (state == S_RD_ISSUE) && (lat_cnt == LAT_LAST);

`ifdef ABUS_READ_CACHE_EN
    logic [31:0] cache_data;
    logic [11:0] cache_addr;
    logic        cache_valid;
    logic        cache_hit;

    assign cache_hit = cache_valid && (cache_addr == abus_addr[12:1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid <= 1'b0;
            cache_data  <= 32'h0;
            cache_addr  <= 12'h0;
        end else if (state == S_IDLE && wr_edge) begin
            if (cache_hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_be[b])
                        cache_data[8*b +: 8] <= abus_wdata[8*(b%2) +: 8];
                end
            end
        end else if (capture) begin
            cache_data  <= avm_readdata;
            cache_addr  <= avm_address;
            cache_valid <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            rd_q           <= 1'b0;
            wr_q           <= 2'b00;
            lat_cnt        <= 2'd0;
            rd_upper       <= 1'b0;
            abus_rdata     <= 16'h0;
            abus_wait      <= 1'b0;
            avm_address    <= 12'h0;
            avm_byteenable <= 4'h0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= 32'h0;
        end else begin
            rd_q <= abus_rd;
            wr_q <= abus_wr;
            case (state)
                S_IDLE: begin
                    // A simultaneous read edge is dropped in favour of the write.
                    if (wr_edge) begin
                        state          <= S_WR_ISSUE;
                        avm_address    <= abus_addr[12:1];
                        avm_byteenable <= wr_be;
                        avm_writedata  <= {abus_wdata, abus_wdata};
                        avm_chipselect <= 1'b1;
                        avm_write      <= 1'b1;
                        abus_wait      <= 1'b1;
                    end else if (rd_edge) begin
`ifdef ABUS_READ_CACHE_EN
                        if (cache_hit) begin
                            abus_rdata <= upper_sel ? cache_data[31:16] : cache_data[15:0];
                            state      <= S_HOLD;
                        end else begin
`else
                        begin
`endif
                            state          <= S_RD_ISSUE;
                            avm_address    <= abus_addr[12:1];
                            avm_byteenable <= 4'hF;
                            avm_chipselect <= 1'b1;
                            avm_write      <= 1'b0;
                            abus_wait      <= 1'b1;
                            lat_cnt        <= 2'd0;
                            rd_upper       <= upper_sel;
                        end
                    end
                end
                S_WR_ISSUE: begin
                    state          <= S_HOLD;
                    avm_address    <= 12'h0;
                    avm_byteenable <= 4'h0;
                    avm_writedata  <= 32'h0;
                    avm_chipselect <= 1'b0;
                    avm_write      <= 1'b0;
                    abus_wait      <= 1'b0;
                end
                S_RD_ISSUE: begin
                    if (capture) begin
                        abus_rdata     <= rd_upper ? avm_readdata[31:16] : avm_readdata[15:0];
                        state          <= S_HOLD;
                        avm_address    <= 12'h0;
                        avm_byteenable <= 4'h0;
                        avm_chipselect <= 1'b0;
                        abus_wait      <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                S_HOLD: begin
                    if (strobes_idle)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_abus_avalon_bridge.sv
// tb/tb_abus_avalon_bridge.sv - directed self-checking bench for abus_avalon_bridge
module tb_abus_avalon_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        abus_cs;
    logic        abus_rd;
    logic [1:0]  abus_wr;
    logic [12:0] abus_addr;
    logic [15:0] abus_wdata;
    logic [15:0] abus_rdata;
    logic        abus_wait;
    logic [11:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_chipselect;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;

    int total = 0;
    int bad   = 0;
    int cs_cycles = 0;
    int wait_cycles = 0;
    int xfers = 0;
    logic cs_prev = 1'b0;
    logic mem_clr;
    int c0, w0, x0;

    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    abus_avalon_bridge #(.READ_LATENCY(1), .HALF_SWAP(0)) dut (
        .clk(clk), .reset(reset),
        .abus_cs(abus_cs), .abus_rd(abus_rd), .abus_wr(abus_wr),
        .abus_addr(abus_addr), .abus_wdata(abus_wdata),
        .abus_rdata(abus_rdata), .abus_wait(abus_wait),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
    );

    // On-chip RAM, read latency 1.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
        end else if (avm_chipselect && avm_write) begin
            for (int b = 0; b < 4; b++)
                if (avm_byteenable[b]) mem[avm_address][8*b +: 8] <= avm_writedata[8*b +: 8];
        end
        avm_readdata <= mem[avm_address];
    end

    always @(negedge clk) begin
        if (avm_chipselect) cs_cycles++;
        if (abus_wait) wait_cycles++;
        if (avm_chipselect && !cs_prev) xfers++;
        cs_prev = avm_chipselect;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus;
        abus_cs = 1'b0; abus_rd = 1'b0; abus_wr = 2'b00;
        tick; tick;
    endtask

    task automatic drive_wr(input logic [12:0] a, input logic [15:0] d, input logic [1:0] w);
        abus_cs = 1'b1; abus_addr = a; abus_wdata = d; abus_wr = w;
    endtask

    task automatic drive_rd(input logic [12:0] a);
        abus_cs = 1'b1; abus_addr = a; abus_rd = 1'b1;
    endtask

    task automatic write_word(input logic [12:0] a, input logic [15:0] d, input logic [1:0] w);
        drive_wr(a, d, w);
        tick; tick;
        idle_bus;
    endtask

    initial begin
        reset = 1'b1; mem_clr = 1'b1;
        abus_cs = 1'b0; abus_rd = 1'b0; abus_wr = 2'b00;
        abus_addr = 13'h0; abus_wdata = 16'h0;
        tick; tick;
        check("rst_cs", {31'h0, avm_chipselect}, 32'h0);
        check("rst_write", {31'h0, avm_write}, 32'h0);
        check("rst_wait", {31'h0, abus_wait}, 32'h0);
        check("rst_rdata", {16'h0, abus_rdata}, 32'h0);
        check("rst_addr_be", {16'h0, avm_address, avm_byteenable}, 32'h0);
        check("rst_wdata", avm_writedata, 32'h0);
        reset = 1'b0; mem_clr = 1'b0;
        tick;

        // Upper-half full write
        c0 = cs_cycles; w0 = wait_cycles;
        drive_wr(13'h0004, 16'hA55A, 2'b11);
        tick;
        check("wr_cs", {30'h0, avm_chipselect, avm_write}, 32'h3);
        check("wr_addr", {20'h0, avm_address}, 32'h002);
        check("wr_be", {28'h0, avm_byteenable}, 32'hC);
        check("wr_wdata", avm_writedata, 32'hA55AA55A);
        check("wr_wait_t0", {31'h0, abus_wait}, 32'h1);
        tick;
        check("wr_t1", {30'h0, avm_chipselect, abus_wait}, 32'h0);
        idle_bus;
        check("wr_cs_cycles", cs_cycles - c0, 32'd1);
        check("wr_wait_cycles", wait_cycles - w0, 32'd1);

        write_word(13'h0004, 16'h1234, 2'b11);
        drive_wr(13'h0005, 16'hA55A, 2'b11);
        tick;
        check("wr_lo_be", {28'h0, avm_byteenable}, 32'h3);
        tick;
        idle_bus;

        // Lower-half read, latency 1
        drive_rd(13'h0005);
        tick;
        check("rd_t0", {29'h0, abus_wait, avm_chipselect, avm_write}, 32'h6);
        check("rd_t0_addr_be", {16'h0, avm_address, avm_byteenable}, 32'h002F);
        tick;
        check("rd_t1_wait", {31'h0, abus_wait}, 32'h1);
        check("rd_t1_hold", {16'h0, abus_rdata}, 32'h0);
        tick;
        check("rd_t2_idle", {30'h0, abus_wait, avm_chipselect}, 32'h0);
        check("rd_t2_data", {16'h0, abus_rdata}, 32'hA55A);
        idle_bus;

        // Reset during T0 of a read
        drive_rd(13'h0004);
        tick;
        check("rr_t0_cs", {31'h0, avm_chipselect}, 32'h1);
        reset = 1'b1; abus_rd = 1'b0; abus_cs = 1'b0;
        tick;
        check("rr_outs", {abus_rdata, abus_wait, avm_chipselect, avm_write, 13'h0}, 32'h0);
        check("rr_addr_be", {16'h0, avm_address, avm_byteenable}, 32'h0);
        reset = 1'b0;
        c0 = cs_cycles;
        tick; tick; tick;
        check("rr_no_cs", cs_cycles - c0, 32'd0);
        drive_rd(13'h0004);
        tick; tick; tick;
        check("rr_reread", {16'h0, abus_rdata}, 32'h1234);
        idle_bus;

        // Single-byte write, then rd/wr rising together
        drive_wr(13'h0004, 16'h00BB, 2'b01);
        tick;
        check("b1_be", {28'h0, avm_byteenable}, 32'h4);
        check("b1_wdata", avm_writedata, 32'h00BB00BB);
        tick;
        idle_bus;
        c0 = cs_cycles;
        drive_wr(13'h0005, 16'h7777, 2'b11);
        abus_rd = 1'b1;
        tick;
        check("rw_write", {27'h0, avm_write, avm_byteenable}, 32'h13);
        tick; tick; tick;
        check("rw_no_read", {16'h0, abus_rdata}, 32'h1234);
        idle_bus;
        check("rw_cs_cycles", cs_cycles - c0, 32'd1);

        // Held strobe gives one transfer; re-arm gives another
        x0 = xfers;
        drive_rd(13'h0020);
        repeat (20) tick;
        check("hold_one_xfer", xfers - x0, 32'd1);
        check("hold_rdata", {16'h0, abus_rdata}, 32'h0);
        abus_rd = 1'b0;
        tick; tick;
        abus_addr = 13'h0004; abus_rd = 1'b1;
        repeat (5) tick;
        check("hold_two_xfer", xfers - x0, 32'd2);
        check("rearm_rdata", {16'h0, abus_rdata}, 32'h12BB);
        idle_bus;

`ifdef ABUS_READ_CACHE_EN
        write_word(13'h0010, 16'hCAFE, 2'b11);
        write_word(13'h0011, 16'hBEEF, 2'b11);
        drive_rd(13'h0010);
        tick; tick; tick;
        check("c_miss", {16'h0, abus_rdata}, 32'hCAFE);
        idle_bus;
        c0 = cs_cycles; w0 = wait_cycles;
        drive_rd(13'h0011);
        tick;
        check("c_hit_t0", {15'h0, abus_rdata, abus_wait}, {15'h0, 16'hBEEF, 1'b0});
        tick; tick;
        idle_bus;
        check("c_hit_cs", cs_cycles - c0, 32'd0);
        check("c_hit_wait", wait_cycles - w0, 32'd0);
        write_word(13'h0011, 16'h0012, 2'b01);
        drive_rd(13'h0011);
        tick;
        check("c_merge", {16'h0, abus_rdata}, 32'hBE12);
        idle_bus;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
